// File: rtl/popcount_accumulator.sv
// popcount_accumulator
// Sums NUM_CH successive 4-bit popcounts (one 3x3 XNOR window per channel) into a
// neuron pre-activation and compares it against a threshold to give the sign bit.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// The producer holds in_cnt stable while in_valid is high and in_ready is low. The
// result (out_sum/out_bit) is held, with out_valid high, until out_ready is seen.
// in_ready is combinational from the state and out_ready, so a held result and the
// next beat can both move in the same cycle.
module popcount_accumulator #(
   parameter int NUM_CH = 16,
   parameter int ACC_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [ACC_W-1:0] threshold,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_cnt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_bit,
   output logic             err,
   output logic             fsm_state
);

   // The accumulator cannot overflow when its range exceeds the largest total (9 per beat).
   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("popcount_accumulator: NUM_CH must be at least 1");
   end
   if ((64'd1 << ACC_W) <= 64'(9 * NUM_CH)) begin : g_bad_acc_w
      $error("popcount_accumulator: ACC_W too narrow for 9*NUM_CH");
   end

   localparam int BEAT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_CH - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t             state, state_next;
   logic [ACC_W-1:0]   acc;
   logic [BEAT_W-1:0]  beat;
   logic               illegal;
   logic [3:0]         cnt;
   logic [ACC_W-1:0]   sum;
   logic               accept;
   logic               last;

   // Clamp out-of-range popcounts to the largest legal value of a 3x3 window.
   always_comb begin
      illegal = (in_cnt > 4'd9);
      cnt     = illegal ? 4'd9 : in_cnt;
      sum     = acc + ACC_W'(cnt);
      last    = (beat == LAST_BEAT);
   end

   // Handshake decode; a beat offered during clr is dropped.
   always_comb begin
      in_ready  = (state == ACCUM) || out_ready;
      out_valid = (state == HOLD);
      accept    = in_valid && in_ready && !clr;
      fsm_state = state;
   end

   // Next state: enter HOLD on the last beat, leave it when the result retires
   // unless that same cycle delivered another complete result (NUM_CH == 1).
   always_comb begin
      state_next = state;
      if (clr) begin
         state_next = ACCUM;
      end else begin
         case (state)
            ACCUM: if (accept && last) state_next = HOLD;
            HOLD:  if (out_ready) state_next = (accept && last) ? HOLD : ACCUM;
            default: state_next = ACCUM;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_next;
   end

   // Accumulator, beat counter, result registers and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         beat    <= '0;
         out_sum <= '0;
         out_bit <= 1'b0;
         err     <= 1'b0;
      end else if (clr) begin
         // Result registers keep their last value; only out_valid drops.
         acc  <= '0;
         beat <= '0;
         err  <= 1'b0;
      end else if (accept) begin
         if (illegal) err <= 1'b1;
         if (last) begin
            out_sum <= sum;
            out_bit <= (sum >= threshold);
            acc     <= '0;
            beat    <= '0;
         end else begin
            acc  <= sum;
            beat <= beat + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed bench for popcount_accumulator (NUM_CH=16, ACC_W=8).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_popcount_accumulator;

   localparam int NUM_CH = 16;
   localparam int ACC_W  = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr;
   logic [ACC_W-1:0] threshold;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_cnt;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             out_bit;
   logic             err;
   logic             fsm_state;

   int vectors     = 0;
   int miscompares = 0;
   int got;
   logic [ACC_W:0] exp_q[$];
   logic [ACC_W:0] exp_v;

   popcount_accumulator #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .threshold (threshold),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_cnt    (in_cnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_bit   (out_bit),
      .err       (err),
      .fsm_state (fsm_state)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] c);
      in_valid = 1'b1;
      in_cnt   = c;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      threshold = '0;
      in_valid  = 1'b0;
      in_cnt    = '0;
      out_ready = 1'b1;

      // Reset state.
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_sum", 32'(out_sum), 0);
      check("rst_out_bit", 32'(out_bit), 0);
      check("rst_err", 32'(err), 0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      step();

      // 16 beats of 9 with threshold equal to the total: boundary of >=.
      threshold = 8'd144;
      for (int i = 0; i < 16; i++) begin
         send(4'd9);
         if (i == 14) check("t1_valid_before_last", 32'(out_valid), 0);
      end
      check("t1_valid", 32'(out_valid), 1);
      check("t1_sum", 32'(out_sum), 144);
      check("t1_bit", 32'(out_bit), 1);
      step();
      check("t1_valid_one_cycle", 32'(out_valid), 0);

      // Beats i mod 10: 0+..+9 + 0+..+5 = 60, below threshold 70.
      threshold = 8'd70;
      for (int i = 0; i < 16; i++) send(4'(i % 10));
      check("t2_sum", 32'(out_sum), 60);
      check("t2_bit", 32'(out_bit), 0);
      step();

      // Backpressure: result held 5 cycles, offered beat must wait.
      out_ready = 1'b0;
      threshold = 8'd200;
      for (int i = 0; i < 15; i++) send(4'd1);
      threshold = 8'd16;
      send(4'd1);
      threshold = 8'd200;
      in_valid  = 1'b1;
      in_cnt    = 4'd3;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t3_in_ready_low", 32'(in_ready), 0);
         step();
         check("t3_valid_held", 32'(out_valid), 1);
         check("t3_sum_held", 32'(out_sum), 16);
         check("t3_bit_held", 32'(out_bit), 1);
      end
      out_ready = 1'b1;
      #1;
      check("t3_in_ready_release", 32'(in_ready), 1);
      step();
      check("t3_retired", 32'(out_valid), 0);
      threshold = 8'd48;
      for (int i = 0; i < 15; i++) send(4'd3);
      check("t3_sum_next", 32'(out_sum), 48);
      check("t3_bit_next", 32'(out_bit), 1);
      step();

      // Three neurons back to back, 48 beats in 48 cycles.
      threshold = 8'd48;
      exp_q.push_back({1'b0, 8'd32});
      exp_q.push_back({1'b1, 8'd48});
      exp_q.push_back({1'b1, 8'd64});
      got = 0;
      for (int c = 0; c < 48; c++) begin
         in_valid = 1'b1;
         in_cnt   = 4'(c / 16 + 2);
         #1;
         check("t4_in_ready", 32'(in_ready), 1);
         step();
         if (out_valid) begin
            got++;
            if (exp_q.size() > 0) begin
               exp_v = exp_q.pop_front();
               check("t4_sum", 32'(out_sum), 32'(exp_v[ACC_W-1:0]));
               check("t4_bit", 32'(out_bit), 32'(exp_v[ACC_W]));
            end
         end
      end
      in_valid = 1'b0;
      check("t4_results", 32'(got), 3);
      check("t4_queue_empty", 32'(exp_q.size()), 0);
      step();

      // Illegal popcount on beat 3: clamped to 9, sticky err, cleared by clr.
      threshold = 8'd24;
      for (int i = 0; i < 16; i++) begin
         send((i == 3) ? 4'd15 : 4'd1);
         if (i == 3) check("t5_err_set", 32'(err), 1);
      end
      check("t5_sum", 32'(out_sum), 24);
      check("t5_bit", 32'(out_bit), 1);
      step();
      check("t5_err_sticky", 32'(err), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t5_err_cleared", 32'(err), 0);

      // clr after 7 beats drops the partial sum and the beat offered with it.
      threshold = 8'd33;
      for (int i = 0; i < 7; i++) send(4'd5);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_cnt   = 4'd9;
      step();
      clr      = 1'b0;
      in_valid = 1'b0;
      check("t6_valid_after_clr", 32'(out_valid), 0);
      check("t6_sum_kept", 32'(out_sum), 24);
      for (int i = 0; i < 16; i++) send(4'd2);
      check("t6_sum", 32'(out_sum), 32);
      check("t6_bit", 32'(out_bit), 0);
      out_ready = 1'b0;
      step();
      check("t6_held", 32'(out_valid), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t6_clr_in_hold", 32'(out_valid), 0);
      check("t6_clr_sum_kept", 32'(out_sum), 32);

      // Asynchronous reset mid-HOLD.
      threshold = 8'd0;
      for (int i = 0; i < 16; i++) send(4'd4);
      check("t7_valid", 32'(out_valid), 1);
      check("t7_sum", 32'(out_sum), 64);
      #2;
      rst_n = 1'b0;
      #1;
      check("t7_async_valid", 32'(out_valid), 0);
      check("t7_async_sum", 32'(out_sum), 0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("t7_in_ready", 32'(in_ready), 1);
      step();

      // Reset mid-accumulation discards the partial sum.
      threshold = 8'd17;
      for (int i = 0; i < 5; i++) send(4'd9);
      #2;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 16; i++) send(4'd1);
      check("t8_sum", 32'(out_sum), 16);
      check("t8_bit", 32'(out_bit), 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
